ray_dispatch_scheduler: RTL

Sequences a frame across NUM_CORES ray generator cores and merges their ray outputs into one registered stream for the downstream traversal unit. It pulses each core's enable on frame start, grants one core per cycle with a round-robin arbiter, and counts accepted rays until width*height rays have been forwarded. It then pulses frame_done. It sits between the ray generator array and the traversal/intersection stage.

---
 rtl/ray_dispatch_scheduler.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/ray_dispatch_scheduler.sv
// Frame sequencer for an array of ray generator cores: launches every core, merges their
// rays through a round-robin arbiter into one registered stream, and signals frame end.
module ray_dispatch_scheduler #(
  parameter int NUM_CORES = 4,
  parameter int DIR_W     = 32,
  parameter int IDX_W     = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [12:0]                image_width,
  input  logic [12:0]                image_height,
  output logic [NUM_CORES-1:0]       core_en,
  input  logic [NUM_CORES-1:0]       core_valid,
  output logic [NUM_CORES-1:0]       core_ready,
  input  logic [NUM_CORES*DIR_W-1:0] core_ray_x,
  input  logic [NUM_CORES*DIR_W-1:0] core_ray_y,
  input  logic [NUM_CORES*DIR_W-1:0] core_ray_z,
  input  logic [NUM_CORES*IDX_W-1:0] core_index,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DIR_W-1:0]           out_ray_x,
  output logic [DIR_W-1:0]           out_ray_y,
  output logic [DIR_W-1:0]           out_ray_z,
  output logic [IDX_W-1:0]           out_index,
  output logic                       busy,
  output logic                       frame_done,
  output logic [25:0]                rays_sent
);

  localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_RUN, S_DONE} state_t;

  state_t           state;
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] grant_idx;
  logic [PTR_W-1:0] cand;
  logic [PTR_W:0]   sum;
  logic             grant_found;
  logic             grant_en;
  logic             can_load;
  logic             accept;
  logic             frame_end;
  logic [25:0]      total;
  logic [25:0]      granted;
  logic [25:0]      frame_total;
  logic [DIR_W-1:0] sel_x, sel_y, sel_z;
  logic [IDX_W-1:0] sel_index;

  assign frame_total = 26'(image_width) * 26'(image_height);
  assign busy        = (state != S_IDLE);
  assign core_en     = {NUM_CORES{(state == S_LAUNCH) && (frame_total != 26'd0)}};
  assign can_load    = !out_valid || out_ready;
  assign accept      = out_valid && out_ready;
  assign grant_en    = (state == S_RUN) && can_load && grant_found && (granted < total);
  // The granted-ray counter caps grants, so the final accept always finds an empty pipeline.
  assign frame_end   = (state == S_RUN) && ((rays_sent + 26'(accept)) == total);

  // Round-robin search: first valid core at or above rr_ptr, wrapping at NUM_CORES.
  // NOTE: combinational blocks use blocking assignments and default every output first,
  // so no path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    sum         = '0;
    cand        = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      sum = {1'b0, rr_ptr} + (PTR_W+1)'(k);
      if (sum >= (PTR_W+1)'(NUM_CORES)) sum = sum - (PTR_W+1)'(NUM_CORES);
      cand = sum[PTR_W-1:0];
      if (!grant_found && core_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    core_ready = '0;
    sel_x      = '0;
    sel_y      = '0;
    sel_z      = '0;
    sel_index  = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      if (grant_idx == PTR_W'(k)) begin
        core_ready[k] = grant_en;
        sel_x         = core_ray_x[k*DIR_W +: DIR_W];
        sel_y         = core_ray_y[k*DIR_W +: DIR_W];
        sel_z         = core_ray_z[k*DIR_W +: DIR_W];
        sel_index     = core_index[k*IDX_W +: IDX_W];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      out_valid  <= 1'b0;
      out_ray_x  <= '0;
      out_ray_y  <= '0;
      out_ray_z  <= '0;
      out_index  <= '0;
      rays_sent  <= '0;
      frame_done <= 1'b0;
      rr_ptr     <= '0;
      total      <= '0;
      granted    <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) state <= S_LAUNCH;
        end
        S_LAUNCH: begin
          total     <= frame_total;
          rays_sent <= '0;
          granted   <= '0;
          if (frame_total == 26'd0) begin
            state      <= S_DONE;
            frame_done <= 1'b1;
          end else begin
            state <= S_RUN;
          end
        end
        S_RUN: begin
          if (grant_en) begin
            out_valid <= 1'b1;
            out_ray_x <= sel_x;
            out_ray_y <= sel_y;
            out_ray_z <= sel_z;
            out_index <= sel_index;
            granted   <= granted + 26'd1;
            rr_ptr    <= (grant_idx == PTR_W'(NUM_CORES - 1)) ? '0 : grant_idx + PTR_W'(1);
          end else if (accept) begin
            out_valid <= 1'b0;
          end
          if (accept) rays_sent <= rays_sent + 26'd1;
          if (frame_end) begin
            state      <= S_DONE;
            frame_done <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
